mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_if.sv | 23 ++
 rtl/mem_lsu.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
// Signal names keep the original top-level port names so existing wiring maps one-to-one.
interface mem_lsu_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_be_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [31:0]       bus_wdata_o;
  logic              bus_ack_i;
  logic [31:0]       bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: alignment check, lane steering, single outstanding bus access
// with timeout, and registered writeback/exception reporting towards WB.
module mem_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              wreg_write_i,
  input  logic [4:0]        wreg_addr_i,
  input  logic [31:0]       wreg_data_i,
  mem_lsu_if.master         bus,
  output logic              stall_o,
  output logic              wreg_write_o,
  output logic [4:0]        wreg_addr_o,
  output logic [31:0]       wreg_data_o,
  output logic              exc_o,
  output logic [1:0]        exc_code_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'b0000,
    OP_LB   = 4'b0001,
    OP_LBU  = 4'b0010,
    OP_LH   = 4'b0011,
    OP_LHU  = 4'b0100,
    OP_LW   = 4'b0101,
    OP_SB   = 4'b1001,
    OP_SH   = 4'b1010,
    OP_SW   = 4'b1011
  } op_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        off_q, off_d;
  logic              cw_q, cw_d;
  logic [4:0]        ca_q, ca_d;
  logic [31:0]       cd_q, cd_d;
  logic              wr_q, wr_d;
  logic [4:0]        wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              exc_q, exc_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  logic        is_ld, is_st, sext_w, misal;
  size_e       size_w;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Opcode decode; unlisted encodings fall through as NONE.
  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    size_w = SZ_W;
    sext_w = 1'b0;
    case (mem_op_i)
      OP_LB:   begin is_ld = 1'b1; size_w = SZ_B; sext_w = 1'b1; end
      OP_LBU:  begin is_ld = 1'b1; size_w = SZ_B; end
      OP_LH:   begin is_ld = 1'b1; size_w = SZ_H; sext_w = 1'b1; end
      OP_LHU:  begin is_ld = 1'b1; size_w = SZ_H; end
      OP_LW:   begin is_ld = 1'b1; size_w = SZ_W; end
      OP_SB:   begin is_st = 1'b1; size_w = SZ_B; end
      OP_SH:   begin is_st = 1'b1; size_w = SZ_H; end
      OP_SW:   begin is_st = 1'b1; size_w = SZ_W; end
      default: ;
    endcase
  end

  always_comb begin
    misal   = 1'b0;
    be_w    = 4'b1111;
    wdata_w = mem_wdata_i;
    case (size_w)
      SZ_B: begin
        be_w    = 4'b0001 << mem_addr_i[1:0];
        wdata_w = {4{mem_wdata_i[7:0]}};
      end
      SZ_H: begin
        misal   = mem_addr_i[0];
        be_w    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{mem_wdata_i[15:0]}};
      end
      default: misal = (mem_addr_i[1:0] != 2'b00);
    endcase
  end

  // Load lane extraction uses the byte offset captured at bus entry.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.bus_rdata_i[7:0];
      2'd1:    ld_byte = bus.bus_rdata_i[15:8];
      2'd2:    ld_byte = bus.bus_rdata_i[23:16];
      default: ld_byte = bus.bus_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
    case (size_q)
      SZ_B:    ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
      default: ld_val = bus.bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    cw_d    = cw_q;
    ca_d    = ca_q;
    cd_d    = cd_q;
    wr_d    = wr_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    exc_d   = 1'b0;
    code_d  = code_q;
    bad_d   = bad_q;
    stall_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!valid_i) begin
          wr_d = 1'b0;
        end else if (!(is_ld || is_st)) begin
          wr_d = wreg_write_i;
          wa_d = wreg_addr_i;
          wd_d = wreg_data_i;
        end else if (misal) begin
          wr_d   = 1'b0;
          exc_d  = 1'b1;
          code_d = is_st ? 2'b10 : 2'b01;
          bad_d  = mem_addr_i;
        end else begin
          stall_o = 1'b1;
          wr_d    = 1'b0;
          state_d = S_BUS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = is_st;
          be_d    = be_w;
          addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          wdata_d = wdata_w;
          size_d  = size_w;
          sext_d  = sext_w;
          off_d   = mem_addr_i[1:0];
          cw_d    = wreg_write_i;
          ca_d    = wreg_addr_i;
          cd_d    = wreg_data_i;
        end
      end

      S_BUS: begin
        // Ack is tested first so a same-cycle ack beats the timeout.
        if (bus.bus_ack_i) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          wr_d    = cw_q;
          wa_d    = ca_q;
          wd_d    = we_q ? cd_q : ld_val;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == TMO_MAX) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            wr_d    = 1'b0;
            exc_d   = 1'b1;
            code_d  = 2'b11;
            bad_d   = {addr_q[ADDR_W-1:2], off_q};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      off_q   <= '0;
      cw_q    <= 1'b0;
      ca_q    <= '0;
      cd_q    <= '0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      cw_q    <= cw_d;
      ca_q    <= ca_d;
      cd_q    <= cd_d;
      wr_q    <= wr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;
  assign wreg_write_o    = wr_q;
  assign wreg_addr_o     = wa_q;
  assign wreg_data_o     = wd_q;
  assign exc_o           = exc_q;
  assign exc_code_o      = code_q;
  assign badvaddr_o      = bad_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: expected writebacks/exceptions are queued at issue and matched when
// the unit reports them; bus-side and stall behaviour is checked inline per cycle.
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        wreg_write_i;
  logic [4:0]  wreg_addr_i;
  logic [31:0] wreg_data_i;
  logic        stall_o;
  logic        wreg_write_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;
  logic        exc_o;
  logic [1:0]  exc_code_o;
  logic [31:0] badvaddr_o;

  mem_lsu_if #(.ADDR_W(32)) bus_if ();

  mem_lsu #(.ADDR_W(32), .TMO_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .wreg_write_i (wreg_write_i),
    .wreg_addr_i  (wreg_addr_i),
    .wreg_data_i  (wreg_data_i),
    .bus          (bus_if),
    .stall_o      (stall_o),
    .wreg_write_o (wreg_write_o),
    .wreg_addr_o  (wreg_addr_o),
    .wreg_data_o  (wreg_data_o),
    .exc_o        (exc_o),
    .exc_code_o   (exc_code_o),
    .badvaddr_o   (badvaddr_o)
  );

  typedef struct {
    logic        exc;
    logic [1:0]  code;
    logic [31:0] bad;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every reported writeback or exception must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wreg_write_o === 1'b1 || exc_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", 32'({wreg_write_o, exc_o}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_exc", 32'(exc_o), 32'(mon_e.exc));
        if (mon_e.exc) begin
          check_eq("sb_code", 32'(exc_code_o), 32'(mon_e.code));
          check_eq("sb_badvaddr", badvaddr_o, mon_e.bad);
        end else begin
          check_eq("sb_waddr", 32'(wreg_addr_o), 32'(mon_e.wa));
          check_eq("sb_wdata", wreg_data_o, mon_e.wd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_i      = 1'b0;
    mem_op_i     = 4'b0000;
    wreg_write_i = 1'b0;
  endtask

  task automatic run_none(input logic [3:0] op, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = 32'h0000_0103;
    wreg_write_i = 1'b1; wreg_addr_i = wa; wreg_data_i = wd;
    e.exc = 1'b0; e.code = 2'b00; e.bad = '0; e.wa = wa; e.wd = wd;
    sb.push_back(e);
    #1;
    check_eq("none_stall", 32'(stall_o), 32'd0);
    tick();
    check_eq("none_latency", 32'(wreg_write_o), 32'd1);
    check_eq("none_req", 32'(bus_if.bus_req_o), 32'd0);
    drive_idle();
    tick();
    check_eq("idle_wr_clear", 32'(wreg_write_o), 32'd0);
  endtask

  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wa, input logic [31:0] wd, input int waits,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_bwd, input logic [31:0] exp_wd);
    exp_t e;
    int   stalls;
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
    wreg_write_i = 1'b1; wreg_addr_i = wa; wreg_data_i = wd;
    e.exc = 1'b0; e.code = 2'b00; e.bad = '0; e.wa = wa; e.wd = exp_wd;
    sb.push_back(e);
    #1;
    stalls = (stall_o === 1'b1) ? 1 : 0;
    check_eq("issue_req", 32'(bus_if.bus_req_o), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      tick();
      check_eq("bus_req", 32'(bus_if.bus_req_o), 32'd1);
      check_eq("bus_be", 32'(bus_if.bus_be_o), 32'(exp_be));
      check_eq("bus_addr", bus_if.bus_addr_o, {addr[31:2], 2'b00});
      check_eq("bus_we", 32'(bus_if.bus_we_o), 32'(op[3]));
      if (op[3]) check_eq("bus_wdata", bus_if.bus_wdata_o, exp_bwd);
      if (i == waits) begin
        bus_if.bus_ack_i = 1'b1;
        bus_if.bus_rdata_i = rdata;
        #1;
        check_eq("ack_stall", 32'(stall_o), 32'd0);
      end else if (stall_o === 1'b1) begin
        stalls++;
      end
    end
    tick();
    bus_if.bus_ack_i = 1'b0;
    bus_if.bus_rdata_i = $urandom;
    drive_idle();
    check_eq("done_req", 32'(bus_if.bus_req_o), 32'd0);
    check_eq("wb_latency", 32'(wreg_write_o), 32'd1);
    check_eq("stall_cycles", 32'(stalls), 32'(waits + 1));
  endtask

  task automatic run_misal(input logic [3:0] op, input logic [31:0] addr, input logic [1:0] code);
    exp_t e;
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = 32'h5555_AAAA;
    wreg_write_i = 1'b1; wreg_addr_i = 5'd9; wreg_data_i = 32'h1111_2222;
    e.exc = 1'b1; e.code = code; e.bad = addr; e.wa = '0; e.wd = '0;
    sb.push_back(e);
    #1;
    check_eq("misal_stall", 32'(stall_o), 32'd0);
    check_eq("misal_req", 32'(bus_if.bus_req_o), 32'd0);
    tick();
    check_eq("misal_exc", 32'(exc_o), 32'd1);
    check_eq("misal_wr", 32'(wreg_write_o), 32'd0);
    check_eq("misal_req2", 32'(bus_if.bus_req_o), 32'd0);
    drive_idle();
    tick();
    check_eq("misal_pulse", 32'(exc_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    drive_idle();
    mem_addr_i = '0; mem_wdata_i = '0; wreg_addr_i = '0; wreg_data_i = '0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = '0;

    // Aligned load presented during reset must not stall.
    valid_i = 1'b1; mem_op_i = 4'b0101; mem_addr_i = 32'h100;
    tick();
    tick();
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_req", 32'(bus_if.bus_req_o), 32'd0);
    check_eq("rst_we", 32'(bus_if.bus_we_o), 32'd0);
    check_eq("rst_be", 32'(bus_if.bus_be_o), 32'd0);
    check_eq("rst_addr", bus_if.bus_addr_o, 32'd0);
    check_eq("rst_wdata", bus_if.bus_wdata_o, 32'd0);
    check_eq("rst_wr", 32'(wreg_write_o), 32'd0);
    check_eq("rst_wa", 32'(wreg_addr_o), 32'd0);
    check_eq("rst_wd", wreg_data_o, 32'd0);
    check_eq("rst_exc", 32'(exc_o), 32'd0);
    check_eq("rst_code", 32'(exc_code_o), 32'd0);
    check_eq("rst_bad", badvaddr_o, 32'd0);
    drive_idle();
    rst = 1'b0;
    tick();

    run_none(4'b0000, 5'd5, 32'h1234_5678);
    run_none(4'b0111, 5'd12, 32'hCAFE_0001);

    // Ack in IDLE must be ignored.
    bus_if.bus_ack_i = 1'b1;
    tick();
    bus_if.bus_ack_i = 1'b0;
    check_eq("idle_ack_req", 32'(bus_if.bus_req_o), 32'd0);
    check_eq("idle_ack_wr", 32'(wreg_write_o), 32'd0);

    //       op       addr        wdata         wa     wd            w  rdata         be       bus_wdata     exp_wd
    run_mem(4'b0001, 32'h103, 32'h0,        5'd3,  32'h0,         2, 32'h80AA_BBCC, 4'b1000, 32'h0,        32'hFFFF_FF80);
    run_mem(4'b0100, 32'h202, 32'h0,        5'd4,  32'h0,         0, 32'h8001_FFFF, 4'b1100, 32'h0,        32'h0000_8001);
    run_mem(4'b1001, 32'h301, 32'h0000_00A5, 5'd6, 32'h0BAD_F00D, 1, 32'h0,        4'b0010, 32'hA5A5_A5A5, 32'h0BAD_F00D);
    run_mem(4'b0011, 32'h010, 32'h0,        5'd7,  32'h0,         1, 32'h1234_8001, 4'b0011, 32'h0,        32'hFFFF_8001);
    run_mem(4'b0010, 32'h021, 32'h0,        5'd8,  32'h0,         0, 32'h0000_F000, 4'b0010, 32'h0,        32'h0000_00F0);
    run_mem(4'b1010, 32'h302, 32'h0000_1234, 5'd10, 32'h0000_0077, 0, 32'h0,       4'b1100, 32'h1234_1234, 32'h0000_0077);
    // Ack arriving exactly at the timeout limit wins.
    run_mem(4'b0101, 32'h040, 32'h0,        5'd11, 32'h0,         3, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    run_mem(4'b1011, 32'h044, 32'h8765_4321, 5'd13, 32'h0000_0042, 2, 32'h0,       4'b1111, 32'h8765_4321, 32'h0000_0042);

    run_misal(4'b0101, 32'h06, 2'b01);
    run_misal(4'b1010, 32'h07, 2'b10);
    run_misal(4'b0011, 32'h11, 2'b01);
    run_misal(4'b1011, 32'h0A, 2'b10);

    // Timeout: TMO_MAX=3, request held while counter walks 0..3, then exception.
    valid_i = 1'b1; mem_op_i = 4'b0101; mem_addr_i = 32'h400;
    wreg_write_i = 1'b1; wreg_addr_i = 5'd14;
    e.exc = 1'b1; e.code = 2'b11; e.bad = 32'h400; e.wa = '0; e.wd = '0;
    sb.push_back(e);
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.bus_req_o === 1'b1) begin
        n++;
        tick();
      end
    end
    drive_idle();
    check_eq("tmo_bus_cycles", 32'(n), 32'd4);
    check_eq("tmo_exc", 32'(exc_o), 32'd1);
    check_eq("tmo_wr", 32'(wreg_write_o), 32'd0);
    tick();
    check_eq("tmo_pulse", 32'(exc_o), 32'd0);

    // Reset mid-access: abandon, then a late ack is ignored.
    valid_i = 1'b1; mem_op_i = 4'b0101; mem_addr_i = 32'h500;
    wreg_write_i = 1'b1; wreg_addr_i = 5'd15;
    tick();
    check_eq("rbus_req", 32'(bus_if.bus_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rbus_stall", 32'(stall_o), 32'd0);
    tick();
    rst = 1'b0;
    drive_idle();
    check_eq("rbus_req_drop", 32'(bus_if.bus_req_o), 32'd0);
    check_eq("rbus_wr", 32'(wreg_write_o), 32'd0);
    check_eq("rbus_exc", 32'(exc_o), 32'd0);
    bus_if.bus_ack_i = 1'b1;
    bus_if.bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_if.bus_ack_i = 1'b0;
    check_eq("late_ack_req", 32'(bus_if.bus_req_o), 32'd0);
    check_eq("late_ack_wr", 32'(wreg_write_o), 32'd0);
    check_eq("late_ack_exc", 32'(exc_o), 32'd0);

    tick();
    tick();
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
